io_port_hub: RTL and testbench



---
 rtl/io_port_hub.sv | 229 ++++++++++++++++++++++
 tb/tb_io_port_hub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_hub.sv
// rtl/io_port_hub.sv - cpu port hub: PS/2 scancode FIFO, KBC status/command, CRTC text registers (irq gated by KBC_IRQ_EN)

module kb_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_tvalid,
    input  logic [7:0] s_tdata,
    input  logic       m_tready,
    output logic [7:0] m_tdata,
    input  logic       flush,
    output logic       nonempty,
    output logic       drop
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    last;
    logic          full;
    logic          pop;
    logic          push;

    assign nonempty = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    // A pop on an empty queue is ignored, so a same-cycle push into an
    // empty queue is stored and the reader still sees the last byte.
    assign pop      = m_tready && nonempty;
    // A pop frees the slot a push into a full queue needs; flush discards it.
    assign push     = s_tvalid && (!full || pop) && !flush;
    assign drop     = s_tvalid && full && !pop && !flush;
    assign m_tdata  = nonempty ? mem[rd_ptr] : last;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (pop) begin
                last <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + (AW+1)'(1);
                end else if (pop && !push) begin
                    count <= count - (AW+1)'(1);
                end
            end
        end
    end
endmodule

module io_port_hub #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] PORT_DATA  = 16'h060,
    parameter logic [15:0] PORT_STAT  = 16'h064,
    parameter logic [15:0] PORT_CRTC  = 16'h3D4,
    parameter int          CURSOR_W   = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         pa,
    input  logic                pr,
    input  logic                pw,
    input  logic [7:0]          out,
    output logic [7:0]          pin,
    input  logic                kb_done,
    input  logic [7:0]          kb_data,
    output logic [CURSOR_W-1:0] cursor,
    output logic [CURSOR_W-1:0] start_addr,
    output logic [9:0]          cursor_shape,
    output logic                cursor_off,
    output logic                irq
);
    localparam logic [15:0] PORT_CRTC_DATA = PORT_CRTC + 16'd1;

    logic [7:0]  fifo_tdata;
    logic        nonempty;
    logic        drop;
    logic        overflow;
    logic        irq_en;
    logic [7:0]  index;
    logic [4:0]  shape_start;
    logic [4:0]  shape_end;
    logic [15:0] cursor_ext;
    logic [15:0] start_ext;
    logic [7:0]  crtc_rd;
    logic [7:0]  rd_val;
    logic        rd_hit;
    logic        data_rd;
    logic        stat_rd;
    logic        stat_wr;
    logic        idx_wr;
    logic        crtc_wr;

    assign data_rd = pr && (pa == PORT_DATA);
    assign stat_rd = pr && (pa == PORT_STAT);
    assign stat_wr = pw && (pa == PORT_STAT);
    assign idx_wr  = pw && (pa == PORT_CRTC);
    assign crtc_wr = pw && (pa == PORT_CRTC_DATA);

    // Zero-extended views give a fixed 16-bit high/low byte split for any CURSOR_W.
    assign cursor_ext   = 16'(cursor);
    assign start_ext    = 16'(start_addr);
    assign cursor_shape = {shape_start, shape_end};

    kb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .s_tvalid (kb_done),
        .s_tdata  (kb_data),
        .m_tready (data_rd),
        .m_tdata  (fifo_tdata),
        .flush    (stat_wr && out[0]),
        .nonempty (nonempty),
        .drop     (drop)
    );

    always_comb begin
        crtc_rd = 8'h00;
        case (index)
            8'h0A:   crtc_rd = {2'b00, cursor_off, shape_start};
            8'h0B:   crtc_rd = {3'b000, shape_end};
            8'h0C:   crtc_rd = start_ext[15:8];
            8'h0D:   crtc_rd = start_ext[7:0];
            8'h0E:   crtc_rd = cursor_ext[15:8];
            8'h0F:   crtc_rd = cursor_ext[7:0];
            default: crtc_rd = 8'h00;
        endcase
    end

    // Read data comes from pre-edge state, so a same-cycle write is not seen.
    always_comb begin
        rd_hit = 1'b0;
        rd_val = 8'h00;
        if (pa == PORT_DATA) begin
            rd_hit = 1'b1;
            rd_val = fifo_tdata;
        end else if (pa == PORT_STAT) begin
            rd_hit = 1'b1;
            rd_val = {2'b00, overflow, 3'b000, irq_en, nonempty};
        end else if (pa == PORT_CRTC) begin
            rd_hit = 1'b1;
            rd_val = index;
        end else if (pa == PORT_CRTC_DATA) begin
            rd_hit = 1'b1;
            rd_val = crtc_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pin         <= 8'h00;
            overflow    <= 1'b0;
            irq_en      <= 1'b0;
            index       <= 8'h00;
            shape_start <= 5'd6;
            shape_end   <= 5'd7;
            cursor_off  <= 1'b0;
            cursor      <= '0;
            start_addr  <= '0;
        end else begin
            if (pr && rd_hit) begin
                pin <= rd_val;
            end
            // A new drop in the same cycle as the status read keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (stat_rd) begin
                overflow <= 1'b0;
            end
            if (stat_wr) begin
                irq_en <= out[1];
            end
            if (idx_wr) begin
                index <= out;
            end
            if (crtc_wr) begin
                case (index)
                    8'h0A: begin
                        cursor_off  <= out[5];
                        shape_start <= out[4:0];
                    end
                    8'h0B: shape_end  <= out[4:0];
                    8'h0C: start_addr <= CURSOR_W'({out, start_ext[7:0]});
                    8'h0D: start_addr <= CURSOR_W'({start_ext[15:8], out});
                    8'h0E: cursor     <= CURSOR_W'({out, cursor_ext[7:0]});
                    8'h0F: cursor     <= CURSOR_W'({cursor_ext[15:8], out});
                    default: ;
                endcase
            end
        end
    end

`ifdef KBC_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && nonempty;
        end
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_hub.sv
// tb/tb_io_port_hub.sv - scoreboard bench for io_port_hub

module tb_io_port_hub;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pa = 16'h0;
    logic        pr = 1'b0;
    logic        pw = 1'b0;
    logic [7:0]  out = 8'h0;
    logic [7:0]  pin;
    logic        kb_done = 1'b0;
    logic [7:0]  kb_data = 8'h0;
    logic [10:0] cursor;
    logic [10:0] start_addr;
    logic [9:0]  cursor_shape;
    logic        cursor_off;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_val [$];
    string      exp_name [$];
    logic       rd_seen = 1'b0;
    logic       irq_exp_on;

    io_port_hub dut (
        .clock        (clock),
        .reset        (reset),
        .pa           (pa),
        .pr           (pr),
        .pw           (pw),
        .out          (out),
        .pin          (pin),
        .kb_done      (kb_done),
        .kb_data      (kb_data),
        .cursor       (cursor),
        .start_addr   (start_addr),
        .cursor_shape (cursor_shape),
        .cursor_off   (cursor_off),
        .irq          (irq)
    );

    always #20 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a read strobe accepted on one edge presents pin for the next cycle.
    always @(posedge clock) rd_seen <= pr && !reset;

    always @(negedge clock) begin
        if (rd_seen) begin
            if (exp_val.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got %h expected none", pin);
            end else begin
                check(exp_name.pop_front(), {8'h0, pin}, {8'h0, exp_val.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input string name);
        exp_val.push_back(exp);
        exp_name.push_back(name);
        pa = addr;
        pr = 1'b1;
        tick();
        pr = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d);
        pa = addr;
        out = d;
        pw = 1'b1;
        tick();
        pw = 1'b0;
    endtask

    task automatic kb(input logic [7:0] d);
        kb_data = d;
        kb_done = 1'b1;
        tick();
        kb_done = 1'b0;
    endtask

    initial begin
`ifdef KBC_IRQ_EN
        irq_exp_on = 1'b1;
`else
        irq_exp_on = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        check("rst_pin", {8'h0, pin}, 16'h00);
        check("rst_cursor", {5'h0, cursor}, 16'h000);
        check("rst_start", {5'h0, start_addr}, 16'h000);
        check("rst_shape", {6'h0, cursor_shape}, 16'h0C7);
        check("rst_off", {15'h0, cursor_off}, 16'h0);
        check("rst_irq", {15'h0, irq}, 16'h0);

        rd(16'h064, 8'h00, "stat_after_reset");
        wr(16'h3D4, 8'h0E);
        rd(16'h3D5, 8'h00, "crtc_0e_reset");

        kb(8'h1C);
        kb(8'h32);
        rd(16'h060, 8'h1C, "data_1c");
        rd(16'h060, 8'h32, "data_32");
        rd(16'h060, 8'h32, "empty_hold");
        rd(16'h064, 8'h00, "stat_empty");

        for (int i = 1; i <= 17; i++) kb(8'(i));
        rd(16'h064, 8'h21, "stat_overflow");
        rd(16'h064, 8'h01, "stat_ovf_cleared");
        for (int i = 1; i <= 16; i++) rd(16'h060, 8'(i), "drain_ovf");
        rd(16'h064, 8'h00, "stat_drained");

        for (int i = 0; i < 16; i++) kb(8'h40 + 8'(i));
        kb_data = 8'hAA;
        kb_done = 1'b1;
        rd(16'h060, 8'h40, "full_push_pop");
        kb_done = 1'b0;
        rd(16'h064, 8'h01, "stat_no_ovf");
        for (int i = 1; i < 16; i++) rd(16'h060, 8'h40 + 8'(i), "drain_full");
        rd(16'h060, 8'hAA, "aa_last_entry");
        rd(16'h060, 8'hAA, "aa_hold");

        wr(16'h3D4, 8'h0E);
        wr(16'h3D5, 8'h07);
        wr(16'h3D4, 8'h0F);
        wr(16'h3D5, 8'hD0);
        check("cursor_7d0", {5'h0, cursor}, 16'h7D0);
        wr(16'h3D4, 8'h0A);
        wr(16'h3D5, 8'h20);
        check("cursor_off", {15'h0, cursor_off}, 16'h1);
        check("shape_0a", {6'h0, cursor_shape}, 16'h007);
        rd(16'h3D5, 8'h20, "crtc_0a");
        wr(16'h3D4, 8'h0E);
        rd(16'h3D5, 8'h07, "crtc_0e");
        rd(16'h3D4, 8'h0E, "crtc_index");
        tick();
        check("pin_hold", {8'h0, pin}, 16'h0E);
        wr(16'h3D4, 8'h0C);
        wr(16'h3D5, 8'hFF);
        rd(16'h3D5, 8'h07, "crtc_0c_trunc");
        wr(16'h3D4, 8'h0D);
        wr(16'h3D5, 8'h34);
        check("start_734", {5'h0, start_addr}, 16'h734);
        wr(16'h3D4, 8'h10);
        wr(16'h3D5, 8'h55);
        rd(16'h3D5, 8'h00, "crtc_unmapped");

        wr(16'h3D4, 8'h0E);
        out = 8'h03;
        pw = 1'b1;
        rd(16'h3D5, 8'h07, "rw_same_cycle_old");
        pw = 1'b0;
        check("cursor_3d0", {5'h0, cursor}, 16'h3D0);
        rd(16'h3D5, 8'h03, "rw_new");

        kb_data = 8'h77;
        kb_done = 1'b1;
        rd(16'h060, 8'hAA, "empty_push_pop");
        kb_done = 1'b0;
        rd(16'h064, 8'h01, "stat_one");
        rd(16'h060, 8'h77, "data_77");

        kb(8'h11);
        kb(8'h22);
        wr(16'h064, 8'h01);
        rd(16'h064, 8'h00, "stat_flushed");
        rd(16'h060, 8'h77, "flush_keeps_last");

        wr(16'h064, 8'h02);
        rd(16'h064, 8'h02, "stat_irq_en");
        kb(8'h5A);
        tick();
        check("irq_push", {15'h0, irq}, {15'h0, irq_exp_on});
        rd(16'h060, 8'h5A, "data_5a");
        tick();
        check("irq_pop", {15'h0, irq}, 16'h0);
        kb(8'h5B);
        tick();
        check("irq_push2", {15'h0, irq}, {15'h0, irq_exp_on});
        wr(16'h064, 8'h03);
        tick();
        check("irq_flush", {15'h0, irq}, 16'h0);
        rd(16'h064, 8'h02, "stat_after_flush");

        kb(8'h99);
        reset = 1'b1;
        pa = 16'h3D4;
        out = 8'h0F;
        pw = 1'b1;
        pr = 1'b1;
        tick();
        pw = 1'b0;
        pr = 1'b0;
        reset = 1'b0;
        check("midrst_cursor", {5'h0, cursor}, 16'h000);
        check("midrst_shape", {6'h0, cursor_shape}, 16'h0C7);
        check("midrst_pin", {8'h0, pin}, 16'h00);
        rd(16'h064, 8'h00, "midrst_stat");
        rd(16'h3D4, 8'h00, "midrst_index");
        rd(16'h060, 8'h00, "midrst_last");

        repeat (3) tick();
        check("scoreboard_empty", 16'(exp_val.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
